// File: rtl/fifo_read_stream.sv
// Turns the registered-read side of an async FIFO (1-cycle read latency) into a
// valid/ready stream, using a 2-entry skid buffer so a full 1 word/cycle rate holds.
module fifo_read_stream #(
    parameter int BITS = 32
) (
    input  logic            read_clk,
    input  logic            read_rst_n,
    output logic            p_read_en,
    input  logic [BITS-1:0] p_read_data,
    input  logic            p_read_empty,
    output logic            p_out_valid,
    input  logic            p_out_ready,
    output logic [BITS-1:0] p_out_data,
    output logic [1:0]      p_out_level,
    output logic [15:0]     p_out_count
);

    logic [1:0]            occ;
    logic                  inflight;
    logic [1:0][BITS-1:0]  skid;
    logic                  pop;
    logic [1:0]            pending;
    logic [1:0]            committed;
    logic [1:0]            tail;

    assign pop       = p_out_valid & p_out_ready;
    assign pending   = occ + {1'b0, inflight};
    assign committed = pending - {1'b0, pop};
    assign tail      = occ - {1'b0, pop};

    // A pop may only be issued when the word it returns next cycle is sure to have a
    // free skid slot, counting the word already in flight and the one leaving now.
    assign p_read_en = read_rst_n & ~p_read_empty & (committed < 2'd2);

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            occ         <= 2'd0;
            inflight    <= 1'b0;
            skid        <= '0;
            p_out_count <= 16'd0;
        end else begin
            inflight <= p_read_en;
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            if (pop) begin
                skid[0]     <= skid[1];
                p_out_count <= p_out_count + 16'd1;
            end
            // Capture lands behind whatever survives this edge; overrides the shift above
            // when the buffer held a single word that is being popped.
            if (inflight)
                skid[tail[0]] <= p_read_data;
        end
    end

    assign p_out_valid = (occ != 2'd0);
    assign p_out_data  = skid[0];
    assign p_out_level = occ;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: a queue-based FIFO model with 1-cycle read latency feeds
// the DUT; delivered words are scoreboarded against the order words left the FIFO.
module tb_fifo_read_stream;

    localparam int BITS = 32;

    logic            read_clk = 1'b0;
    logic            read_rst_n;
    logic            p_read_en;
    logic [BITS-1:0] p_read_data;
    logic            p_read_empty;
    logic            p_out_valid;
    logic            p_out_ready;
    logic [BITS-1:0] p_out_data;
    logic [1:0]      p_out_level;
    logic [15:0]     p_out_count;

    fifo_read_stream #(.BITS(BITS)) dut (
        .read_clk     (read_clk),
        .read_rst_n   (read_rst_n),
        .p_read_en    (p_read_en),
        .p_read_data  (p_read_data),
        .p_read_empty (p_read_empty),
        .p_out_valid  (p_out_valid),
        .p_out_ready  (p_out_ready),
        .p_out_data   (p_out_data),
        .p_out_level  (p_out_level),
        .p_out_count  (p_out_count)
    );

    always #5 read_clk = ~read_clk;

    int unsigned     n_chk  = 0;
    int unsigned     n_fail = 0;
    logic [BITS-1:0] fq[$];      // words sitting in the FIFO
    logic [BITS-1:0] rd_log[$];  // words popped from the FIFO, not yet delivered
    int unsigned     n_del  = 0;
    int unsigned     n_pops = 0;
    int unsigned     cyc    = 0;
    int unsigned     last_del_cyc = 0;
    logic [15:0]     cnt_model = 16'd0;
    logic [BITS-1:0] last_dv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [BITS-1:0] w);
        fq.push_back(w);
        p_read_empty = 1'b0;
    endtask

    // One read_clk cycle; entered and left just after a negedge with inputs already set.
    task automatic step();
        logic            rd, dpop, hold;
        logic [BITS-1:0] dv, exp;
        #1;
        rd   = p_read_en;
        dpop = p_out_valid && p_out_ready;
        dv   = p_out_data;
        hold = p_out_valid && !p_out_ready;
        chk("rd_en_while_empty", 32'(rd & p_read_empty), 32'd0);
        if (dpop) begin
            chk("sb_nonempty", 32'(rd_log.size() != 0), 32'd1);
            if (rd_log.size() != 0) begin
                exp = rd_log.pop_front();
                chk("data_order", dv, exp);
            end
            cnt_model++;
            n_del++;
            last_del_cyc = cyc;
            last_dv = dv;
        end
        @(posedge read_clk);
        #1;
        if (rd) begin
            exp = fq.pop_front();
            p_read_data = exp;
            rd_log.push_back(exp);
            n_pops++;
        end else begin
            p_read_data = $urandom;
        end
        p_read_empty = (fq.size() == 0);
        cyc++;
        chk("count", 32'(p_out_count), 32'(cnt_model));
        if (hold) begin
            chk("hold_valid", 32'(p_out_valid), 32'd1);
            chk("hold_data", p_out_data, dv);
        end
        @(negedge read_clk);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned k = 0;
        p_out_ready = 1'b1;
        while ((fq.size() != 0 || rd_log.size() != 0 || p_out_valid) && k < budget) begin
            step();
            k++;
        end
        chk("drain_done", 32'(k < budget), 32'd1);
    endtask

    task automatic do_reset();
        read_rst_n = 1'b0;
        #1;
        chk("rst_rd_en", 32'(p_read_en), 32'd0);
        chk("rst_valid", 32'(p_out_valid), 32'd0);
        chk("rst_level", 32'(p_out_level), 32'd0);
        chk("rst_count", 32'(p_out_count), 32'd0);
        chk("rst_data", p_out_data, 32'd0);
        rd_log.delete();
        cnt_model = 16'd0;
        step();
        chk("rst_hold_rd_en", 32'(p_read_en), 32'd0);
        read_rst_n = 1'b1;
    endtask

    initial begin
        int unsigned     k, base, pushed;
        int unsigned     first_cyc;
        logic [BITS-1:0] nxt;

        read_rst_n   = 1'b0;
        p_read_empty = 1'b1;
        p_read_data  = '0;
        p_out_ready  = 1'b0;
        @(negedge read_clk);

        // Reset with FIFO non-empty
        push(32'hDEAD_0001);
        do_reset();
        drain(20);
        chk("rst_drain_count", 32'(p_out_count), 32'd1);
        do_reset();

        // Streaming 0x1..0x10 with ready high: latency and throughput
        p_out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(BITS'(i));
        #1;
        chk("lat_rd_en", 32'(p_read_en), 32'd1);
        step();
        chk("lat_valid_n", 32'(p_out_valid), 32'd0);
        step();
        chk("lat_valid_n1", 32'(p_out_valid), 32'd1);
        chk("lat_first", p_out_data, 32'h1);
        first_cyc = cyc;
        base = n_del;
        k = 0;
        while (n_del - base < 16 && k < 100) begin step(); k++; end
        chk("stream_words", n_del - base, 32'd16);
        chk("stream_rate", last_del_cyc - first_cyc, 32'd15);
        chk("stream_last", last_dv, 32'h10);
        chk("stream_count", 32'(p_out_count), 32'd16);
        drain(20);

        // Backpressure: 10 words, ready low
        p_out_ready = 1'b0;
        base = n_pops;
        for (int i = 0; i < 10; i++) push(32'hB000_0000 + 32'(i));
        for (int i = 0; i < 10; i++) step();
        chk("bp_pops", n_pops - base, 32'd2);
        chk("bp_level", 32'(p_out_level), 32'd2);
        chk("bp_valid", 32'(p_out_valid), 32'd1);
        chk("bp_data", p_out_data, 32'hB000_0000);
        base = n_del;
        drain(60);
        chk("bp_delivered", n_del - base, 32'd10);
        chk("bp_level_end", 32'(p_out_level), 32'd0);

        // Random ready toggle with bursty producer
        base = n_del;
        pushed = 0;
        k = 0;
        while (n_del - base < 200 && k < 4000) begin
            for (int j = 0; j < 2; j++)
                if (pushed < 200 && $urandom_range(0, 2) != 0) begin
                    push($urandom);
                    pushed++;
                end
            p_out_ready = 1'($urandom);
            step();
            k++;
        end
        chk("rand_delivered", n_del - base, 32'd200);
        drain(20);

        // Reset after 5 of 12 words delivered
        p_out_ready = 1'b1;
        base = n_del;
        for (int i = 0; i < 12; i++) push(32'hC000_0000 + 32'(i));
        k = 0;
        while (n_del - base < 5 && k < 50) begin step(); k++; end
        chk("mid_five", n_del - base, 32'd5);
        nxt = fq[0];
        do_reset();
        chk("mid_count", 32'(p_out_count), 32'd0);
        base = n_del;
        k = 0;
        while (n_del == base && k < 20) begin step(); k++; end
        chk("mid_next_word", last_dv, nxt);
        drain(30);

        // Counter wrap: 65537 deliveries after reset
        do_reset();
        p_out_ready = 1'b1;
        pushed = 0;
        k = 0;
        while (pushed < 65537 && k < 70000) begin
            if (fq.size() < 3) begin push(BITS'(pushed)); pushed++; end
            step();
            k++;
        end
        drain(20);
        chk("wrap_count", 32'(p_out_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
